// File: rtl/vga_scanout.sv
// vga_scanout: raster scan-out from the frame-buffer RAM read port to a VGA monitor.
// The counters generate the RAM read address and enable in raster order. Sync, blank and
// first-pixel flags go through a delay line that matches the two-cycle RAM read latency.
// RGB, syncs, blank and frame_start leave the block aligned, 4 cycles after the counter state.
// Optional feature macro: VGA_SCANOUT_PALETTE_EN adds a writable 16-entry colour palette.
// Without it, pixels use a fixed grey ramp.

module vga_scanout #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int DATA_SIZE = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  output logic                        rd_en,
  output logic [18:0]                 rd_addr,
  input  logic signed [DATA_SIZE-1:0] rd_data,
  output logic [3:0]                  red,
  output logic [3:0]                  green,
  output logic [3:0]                  blue,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        blank,
  output logic                        frame_start
`ifdef VGA_SCANOUT_PALETTE_EN
  ,
  input  logic                        pal_wr_en,
  input  logic [3:0]                  pal_wr_idx,
  input  logic [11:0]                 pal_wr_data
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  // Raster position and running frame-buffer address
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [18:0]   r_addr;

  // Delay line; index 0 is the stage registered with rd_en/rd_addr, index 2 lines up with rd_data
  logic [2:0]    r_act_p;
  logic [2:0]    r_hs_p;
  logic [2:0]    r_vs_p;
  logic [2:0]    r_first_p;
  logic [18:0]   r_rd_addr;

  // Output stage
  logic [11:0]   r_rgb;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_blank;
  logic          r_frame_start;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_active;
  logic          w_hs_raw;
  logic          w_vs_raw;
  logic          w_first;
  logic [3:0]    w_idx;
  logic [11:0]   w_colour;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_active = (r_h < H_ACT_END) && (r_v < V_ACT_END);
  assign w_hs_raw = !((r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END));
  assign w_vs_raw = !((r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END));
  assign w_first  = (r_h == '0) && (r_v == '0);

  // Only the low nibble of the pixel selects a colour; it is used as an unsigned index
  assign w_idx = rd_data[3:0];

`ifdef VGA_SCANOUT_PALETTE_EN
  logic [11:0] r_pal [16];

  // Palette register file: reset to the grey ramp, written one entry per cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        r_pal[i] <= {3{4'(i) ^ 4'h8}};
      end
    end else if (pal_wr_en) begin
      r_pal[pal_wr_idx] <= pal_wr_data;
    end
  end

  // Same-cycle write is not forwarded: the colour stage sees the pre-write entry
  assign w_colour = r_pal[w_idx];
`else
  // Flipping the sign bit turns -8..7 into 0..15, so the ramp runs black to white
  assign w_colour = {3{w_idx ^ 4'h8}};
`endif

  // Raster counters; the address restarts with the frame, so no v*H_ACTIVE multiply is needed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_h    <= '0;
      r_v    <= '0;
      r_addr <= '0;
    end else begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
      if (w_h_last && w_v_last) begin
        r_addr <= '0;
      end else if (w_active) begin
        r_addr <= r_addr + 19'd1;
      end
    end
  end

  // Stage 0 read request plus the three-deep flag delay line that spans the RAM latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr <= '0;
      r_act_p   <= '0;
      r_hs_p    <= '1;
      r_vs_p    <= '1;
      r_first_p <= '0;
    end else begin
      r_rd_addr <= r_addr;
      r_act_p   <= {r_act_p[1:0], w_active};
      r_hs_p    <= {r_hs_p[1:0], w_hs_raw};
      r_vs_p    <= {r_vs_p[1:0], w_vs_raw};
      r_first_p <= {r_first_p[1:0], w_first};
    end
  end

  // Colour stage: rd_data is only meaningful when the delayed active flag is set
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb         <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_rgb         <= r_act_p[2] ? w_colour : 12'h000;
      r_hsync       <= r_hs_p[2];
      r_vsync       <= r_vs_p[2];
      r_blank       <= !r_act_p[2];
      r_frame_start <= r_first_p[2];
    end
  end

  assign rd_en       = r_act_p[0];
  assign rd_addr     = r_rd_addr;
  assign red         = r_rgb[11:8];
  assign green       = r_rgb[7:4];
  assign blue        = r_rgb[3:0];
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;

endmodule
